// File: rtl/decode_imm_sequencer.sv
// Decode stage between fetch and execute: classifies the RV32I opcode, builds the
// sign-extended immediate and hands a registered packet to execute through a
// 2-entry skid buffer. Flush empties the buffer; illegal encodings are counted.
module decode_imm_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_imm_type,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // Packet layout: {instr, pc, imm, imm_type, illegal}
  localparam int unsigned PKT_W = 32 + 2 * XLEN + 3 + 1;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q;
  logic [PKT_W-1:0] main_q, main_d, skid_q;
  logic             main_load, skid_load;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       dec_type;
  logic             dec_illegal;
  logic [XLEN-1:0]  dec_imm;
  logic [PKT_W-1:0] dec_pkt;
  logic             accept;

  // Classify the incoming opcode and build its immediate.
  always_comb begin
    dec_type    = IMM_NONE;
    dec_illegal = 1'b0;
    dec_imm     = '0;
    unique case (in_instr[6:0])
      7'b0110111, 7'b0010111: dec_type = IMM_U;
      7'b1101111:             dec_type = IMM_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: dec_type = IMM_I;
      7'b0100011:             dec_type = IMM_S;
      7'b1100011:             dec_type = IMM_B;
      7'b0110011:             dec_type = IMM_NONE;
      default:                dec_illegal = 1'b1;
    endcase
    unique case (dec_type)
      IMM_I: dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S: dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B: dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      IMM_U: dec_imm = {in_instr[31:12], 12'b0};
      IMM_J: dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: dec_imm = '0;
    endcase
  end

  assign dec_pkt = {in_instr, in_pc, dec_imm, dec_type, dec_illegal};
  assign accept  = in_valid && in_ready_q;

  // Skid-buffer next state; flush beats every other event.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = dec_pkt;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !out_ready) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (accept) begin
            main_load = 1'b1;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so nothing is accepted while skid drains.
          if (out_ready) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating illegal-packet counter; flushed packets do not count.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_illegal && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, packet and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      cnt_q      <= cnt_d;
      if (main_load) main_q <= main_d;
      if (skid_load) skid_q <= dec_pkt;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != ST_EMPTY);
  assign out_instr     = main_q[PKT_W-1 -: 32];
  assign out_pc        = main_q[2*XLEN+3 -: XLEN];
  assign out_imm       = main_q[XLEN+3 -: XLEN];
  assign out_imm_type  = main_q[3:1];
  assign out_illegal   = main_q[0];
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_imm_sequencer.sv
// Bench for decode_imm_sequencer: directed scenarios plus randomized traffic
// against a queue-based reference model. A second instance with CNT_W=2 shares
// all inputs to exercise counter saturation.
module tb_decode_imm_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [2:0]  out_imm_type;
  logic [15:0] illegal_count;

  logic        d2_in_ready, d2_out_valid, d2_out_illegal;
  logic [31:0] d2_out_instr, d2_out_pc, d2_out_imm;
  logic [2:0]  d2_out_imm_type;
  logic [1:0]  d2_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } pkt_t;

  pkt_t        q[$];
  int unsigned cnt;

  always #5 clk = ~clk;

  decode_imm_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm), .out_imm_type(out_imm_type),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  decode_imm_sequencer #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_instr(d2_out_instr), .out_pc(d2_out_pc), .out_imm(d2_out_imm),
    .out_imm_type(d2_out_imm_type), .out_illegal(d2_out_illegal), .illegal_count(d2_count)
  );

  // Reference decode written as shift/mask arithmetic on the instruction word.
  function automatic pkt_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    pkt_t        p;
    logic [31:0] sgn;
    sgn     = 32'($signed(instr) >>> 31);
    p.instr = instr;
    p.pc    = pc;
    p.ill   = 1'b0;
    p.typ   = 3'd0;
    p.imm   = 32'd0;
    case (instr[6:0])
      7'h37, 7'h17:                      p.typ = 3'd4;
      7'h6F:                             p.typ = 3'd5;
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: p.typ = 3'd1;
      7'h23:                             p.typ = 3'd2;
      7'h63:                             p.typ = 3'd3;
      7'h33:                             p.typ = 3'd0;
      default:                           p.ill = 1'b1;
    endcase
    case (p.typ)
      3'd1: p.imm = 32'($signed(instr) >>> 20);
      3'd2: p.imm = (32'($signed(instr) >>> 25) << 5) | 32'(instr[11:7]);
      3'd3: p.imm = (sgn << 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5)
                    | (32'(instr[11:8]) << 1);
      3'd4: p.imm = instr & 32'hFFFF_F000;
      3'd5: p.imm = (sgn << 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11)
                    | (32'(instr[30:21]) << 1);
      default: p.imm = 32'd0;
    endcase
    return p;
  endfunction

  function automatic int unsigned sat3(input int unsigned n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    flush     = fl;
    out_ready = rdy;
  endtask

  // Advance the model by the events implied by the current inputs, then clock.
  task automatic tick();
    pkt_t p;
    bit   acc, fire;
    if (rst) begin
      q.delete();
      cnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      acc  = in_valid && (q.size() < 2);
      fire = (q.size() > 0) && out_ready;
      if (fire) void'(q.pop_front());
      if (acc) begin
        p = ref_decode(in_instr, in_pc);
        q.push_back(p);
        if (p.ill && cnt < 65535) cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    checks++;
    if ({out_instr, out_pc, out_imm, out_imm_type, out_illegal, illegal_count} !== '0) begin
      errors++;
      $display("FAIL reset_data got instr=%h pc=%h imm=%h type=%0d ill=%b cnt=%0d want all 0",
               out_instr, out_pc, out_imm, out_imm_type, out_illegal, illegal_count);
    end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_imm_type !== 3'd1 ||
        out_pc !== 32'h100) begin
      errors++;
      $display("FAIL addi got v=%b imm=%h type=%0d pc=%h want v=1 imm=ffffffff type=1 pc=100",
               out_valid, out_imm, out_imm_type, out_pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[4];
    logic [31:0] imm[4];
    logic [2:0]  typ[4];
    ins = '{32'h00112423, 32'hFE000EE3, 32'h123450B7, 32'h8000006F};
    // FE000EE3 is beq x0,x0,-4
    imm = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'hFFF00000};
    typ = '{3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i], 32'h200 + 32'(4 * i), 1'b0, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== ins[i] || out_imm !== imm[i] ||
          out_imm_type !== typ[i] || out_pc !== 32'h200 + 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b instr=%h imm=%h type=%0d want instr=%h imm=%h type=%0d",
                 i, out_valid, out_instr, out_imm, out_imm_type, ins[i], imm[i], typ[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] p[3];
    p = '{32'h00500093, 32'h00112423, 32'h123450B7};
    drive(1'b1, p[0], 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, p[1], 32'h304, 1'b0, 1'b0);
    tick();
    drive(1'b1, p[2], 32'h308, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== p[0] ||
          out_pc !== 32'h300) begin
        errors++;
        $display("FAIL stall_hold_%0d got ready=%b v=%b instr=%h pc=%h want 0 1 %h 300",
                 i, in_ready, out_valid, out_instr, out_pc, p[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (out_instr !== p[0]) begin
      errors++;
      $display("FAIL stall_first got instr=%h want %h", out_instr, p[0]);
    end
    tick();
    checks++;
    if (out_instr !== p[1] || out_pc !== 32'h304 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_second got instr=%h pc=%h ready=%b want %h 304 1",
               out_instr, out_pc, in_ready, p[1]);
    end
    tick();
    checks++;
    if (out_instr !== p[2] || out_pc !== 32'h308 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_third got instr=%h pc=%h v=%b want %h 308 1",
               out_instr, out_pc, out_valid, p[2]);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup got in_ready=%b want 0", in_ready);
    end
    drive(1'b1, 32'h00300093, 32'h408, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush got v=%b ready=%b want v=0 ready=1", out_valid, in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 32'h0000007F, 32'h500, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_illegal !== 1'b1 || out_imm !== 32'h0 || out_imm_type !== 3'd0 ||
        illegal_count !== 16'd1) begin
      errors++;
      $display("FAIL illegal_7f got ill=%b imm=%h type=%0d cnt=%0d want 1 0 0 1",
               out_illegal, out_imm, out_imm_type, illegal_count);
    end
    drive(1'b1, 32'h00000000, 32'h504, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_illegal !== 1'b1 || out_imm !== 32'h0 || illegal_count !== 16'd2) begin
      errors++;
      $display("FAIL illegal_00 got ill=%b imm=%h cnt=%0d want 1 0 2",
               out_illegal, out_imm, illegal_count);
    end
    drive(1'b1, 32'h0000007F, 32'h508, 1'b1, 1'b1);
    tick();
    checks++;
    if (illegal_count !== 16'd2) begin
      errors++;
      $display("FAIL illegal_flushed got cnt=%0d want 2", illegal_count);
    end
    drive(1'b1, 32'h0000000B, 32'h50C, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h0000007F, 32'h510, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (illegal_count !== 16'd4 || d2_count !== 2'd3) begin
      errors++;
      $display("FAIL illegal_sat got cnt=%0d cnt2=%0d want 4 3", illegal_count, d2_count);
    end
    tick();
  endtask

  task automatic test_reset_two();
    drive(1'b1, 32'h0000007F, 32'h600, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00100093, 32'h604, 1'b0, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || illegal_count === 16'd0) begin
      errors++;
      $display("FAIL rst_two_setup got ready=%b cnt=%0d want ready=0 cnt>0",
               in_ready, illegal_count);
    end
    rst = 1'b1;
    drive(1'b1, 32'h00200093, 32'h608, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 16'd0 ||
        d2_count !== 2'd0) begin
      errors++;
      $display("FAIL rst_two got v=%b ready=%b cnt=%0d cnt2=%0d want 0 1 0 0",
               out_valid, in_ready, illegal_count, d2_count);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops[14];
    logic [31:0] r, instr;
    int          bad;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h33,
            7'h7F, 7'h00, 7'h0B};
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      r     = $urandom();
      instr = ($urandom_range(7) == 0) ? $urandom() : {r[31:7], ops[$urandom_range(13)]};
      rst   = ($urandom_range(199) == 0);
      drive($urandom_range(2) != 0, instr, $urandom(), $urandom_range(19) == 0,
            $urandom_range(3) != 0);
      tick();
      if (bad < 10) begin
        checks++;
        if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
          errors++; bad++;
          $display("FAIL rand_hs cyc %0d got v=%b ready=%b want v=%b ready=%b",
                   c, out_valid, in_ready, q.size() != 0, q.size() < 2);
        end
        checks++;
        if (illegal_count !== 16'(cnt) || d2_count !== 2'(sat3(cnt))) begin
          errors++; bad++;
          $display("FAIL rand_cnt cyc %0d got cnt=%0d cnt2=%0d want %0d %0d",
                   c, illegal_count, d2_count, cnt, sat3(cnt));
        end
        if (q.size() != 0) begin
          checks++;
          if (out_instr !== q[0].instr || out_pc !== q[0].pc || out_imm !== q[0].imm ||
              out_imm_type !== q[0].typ || out_illegal !== q[0].ill) begin
            errors++; bad++;
            $display("FAIL rand_pkt cyc %0d got %h/%h/%h/%0d/%b want %h/%h/%h/%0d/%b", c,
                     out_instr, out_pc, out_imm, out_imm_type, out_illegal,
                     q[0].instr, q[0].pc, q[0].imm, q[0].typ, q[0].ill);
          end
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cnt = 0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_two();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
